// File: rtl/scramble_rr_sched_pkg.sv
// ---------------------------------------------------------------------------
// scramble_sched_pkg
// Shared types and constants for the scrambler round-robin scheduler.
//   sched_state_t : scheduler FSM states (IDLE -> ISSUE -> WAIT -> RESP)
//   *_DEF         : default parameter values for the scheduler
//   wait_cnt_w()  : width of the WAIT-state cycle counter for a given TIMEOUT
// ---------------------------------------------------------------------------
package scramble_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sched_state_t;

   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF  = 6;
   localparam int TIMEOUT_DEF = 64;
   localparam int STAT_W      = 8;

   // The counter only has to reach TIMEOUT-1 before the job is aborted.
   function automatic int wait_cnt_w(input int timeout);
      return (timeout <= 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/scramble_rr_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker.
//   req        in  NUM_REQ  request levels
//   last_owner in  IDX_W    index served most recently
//   winner     out IDX_W    first set request after last_owner (with wrap)
//   valid      out 1        any request present
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_owner,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   // Distances are scanned from farthest to nearest so the nearest
   // requester after last_owner is the final (winning) assignment.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (((int'(last_owner) + k) % NUM_REQ) == i && req[i]) begin
               winner = IDX_W'(i);
               valid  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/scramble_rr_sched.sv
// ---------------------------------------------------------------------------
// scramble_rr_sched
// Round-robin scheduler sharing one scrambler core among NUM_REQ requesters.
// A granted word is launched with a one-cycle low core_stbi, the scheduler
// waits for core_done (or TIMEOUT cycles) and pulses rsp_valid to the owner.
//
// Ports:
//   clock, reset   clock and synchronous active-high reset
//   req, req_data  per-requester request level and packed request words
//   gnt            one-hot grant pulse (req_data captured on that edge)
//   rsp_valid      one-hot response pulse; rsp_data/rsp_err hold until next
//   busy           high whenever the FSM is not IDLE
//   core_stbi      core strobe, idle high, low one cycle per launch
//   core_x_in      word presented to the core
//   core_done      core result-updated pulse, core_x_out the result
//   stat_jobs      (SCHED_STATS_EN) per-requester saturating good-job counts
//   stat_timeouts  (SCHED_STATS_EN) saturating timeout count
//
// Build option: define SCHED_STATS_EN to add the statistics counters/ports.
// ---------------------------------------------------------------------------
module scramble_rr_sched
   import scramble_sched_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err,
   output logic                      busy,
   output logic                      core_stbi,
   output logic [DATA_W-1:0]         core_x_in,
   input  logic                      core_done,
   input  logic [DATA_W-1:0]         core_x_out
`ifdef SCHED_STATS_EN
   ,
   output logic [NUM_REQ*STAT_W-1:0] stat_jobs,
   output logic [STAT_W-1:0]         stat_timeouts
`endif
);

   localparam int IDX_W = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ);
   localparam int CNT_W = wait_cnt_w(TIMEOUT);

   sched_state_t       state, state_nxt;
   logic [IDX_W-1:0]   last_owner, last_owner_nxt;
   logic [IDX_W-1:0]   owner, owner_nxt;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
   logic [DATA_W-1:0]  r_data, r_data_nxt;
   logic [NUM_REQ-1:0] gnt_nxt, rsp_valid_nxt;
   logic [DATA_W-1:0]  rsp_data_nxt, core_x_in_nxt;
   logic               rsp_err_nxt, core_stbi_nxt;

   logic [IDX_W-1:0]   pick_idx;
   logic               pick_vld;
   logic [DATA_W-1:0]  pick_word;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req        (req),
      .last_owner (last_owner),
      .winner     (pick_idx),
      .valid      (pick_vld)
   );

   always_comb begin
      pick_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) pick_word = req_data[i*DATA_W +: DATA_W];
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nxt      = state;
      last_owner_nxt = last_owner;
      owner_nxt      = owner;
      wait_cnt_nxt   = wait_cnt;
      r_data_nxt     = r_data;
      gnt_nxt        = '0;
      rsp_valid_nxt  = '0;
      rsp_data_nxt   = rsp_data;
      rsp_err_nxt    = rsp_err;
      core_stbi_nxt  = 1'b1;
      core_x_in_nxt  = core_x_in;

      case (state)
         IDLE: begin
            if (pick_vld) begin
               gnt_nxt       = NUM_REQ'(1) << pick_idx;
               owner_nxt     = pick_idx;
               r_data_nxt    = pick_word;
               core_x_in_nxt = pick_word;
               core_stbi_nxt = 1'b0;
               state_nxt     = ISSUE;
            end
         end
         ISSUE: begin
            // core_done is deliberately ignored while the strobe is low.
            wait_cnt_nxt = '0;
            state_nxt    = WAIT;
         end
         WAIT: begin
            wait_cnt_nxt  = wait_cnt + CNT_W'(1);
            core_x_in_nxt = r_data;
            // done has priority over a coincident timeout
            if (core_done) begin
               rsp_data_nxt = core_x_out;
               rsp_err_nxt  = 1'b0;
               state_nxt    = RESP;
            end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
               rsp_data_nxt = '0;
               rsp_err_nxt  = 1'b1;
               state_nxt    = RESP;
            end
         end
         RESP: begin
            rsp_valid_nxt  = NUM_REQ'(1) << owner;
            last_owner_nxt = owner;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         last_owner <= IDX_W'(NUM_REQ - 1);
         owner      <= '0;
         wait_cnt   <= '0;
         gnt        <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
         core_stbi  <= 1'b1;
         core_x_in  <= '0;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
         owner      <= owner_nxt;
         wait_cnt   <= wait_cnt_nxt;
         gnt        <= gnt_nxt;
         rsp_valid  <= rsp_valid_nxt;
         rsp_data   <= rsp_data_nxt;
         rsp_err    <= rsp_err_nxt;
         busy       <= (state_nxt != IDLE);
         core_stbi  <= core_stbi_nxt;
         core_x_in  <= core_x_in_nxt;
      end
   end

   // Job word captured at grant; pure data, so it carries no reset.
   always_ff @(posedge clock) begin
      r_data <= r_data_nxt;
   end

`ifdef SCHED_STATS_EN
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
   endfunction

   // rsp_err already reflects the finishing job while in RESP.
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_jobs     <= '0;
         stat_timeouts <= '0;
      end else if (state == RESP) begin
         if (rsp_err) begin
            stat_timeouts <= sat_inc(stat_timeouts);
         end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (owner == IDX_W'(i))
                  stat_jobs[i*STAT_W +: STAT_W] <= sat_inc(stat_jobs[i*STAT_W +: STAT_W]);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_scramble_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_scramble_rr_sched
// Self-checking bench for scramble_rr_sched (NUM_REQ=4, DATA_W=6, TIMEOUT=64).
// The core model answers x_in ^ 6'h0E a programmable number of cycles after
// the strobe (0 = never). Expected responses are queued when a job is driven
// and compared by a monitor whenever rsp_valid pulses.
// Define SCHED_STATS_EN to also exercise the statistics counters.
// ---------------------------------------------------------------------------
module tb_scramble_rr_sched;

   typedef struct packed {
      logic [3:0] vld;
      logic [5:0] data;
      logic       err;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req   = 4'b0;
   logic [5:0]  words [4];
   logic [23:0] req_data;
   logic [3:0]  gnt, rsp_valid;
   logic [5:0]  rsp_data, core_x_in;
   logic        rsp_err, busy, core_stbi;
   logic        core_done = 1'b0;
   logic [5:0]  core_x_out = 6'h0;
`ifdef SCHED_STATS_EN
   logic [31:0] stat_jobs;
   logic [7:0]  stat_timeouts;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sb [$];
   exp_t mon_e;

   int         core_lat = 0;
   int         core_cnt = 0;
   logic [5:0] core_val = 6'h0;

   assign req_data = {words[3], words[2], words[1], words[0]};

   always #5 clock = ~clock;

   scramble_rr_sched #(.NUM_REQ(4), .DATA_W(6), .TIMEOUT(64)) dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .req_data   (req_data),
      .gnt        (gnt),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .core_stbi  (core_stbi),
      .core_x_in  (core_x_in),
      .core_done  (core_done),
      .core_x_out (core_x_out)
`ifdef SCHED_STATS_EN
      ,
      .stat_jobs     (stat_jobs),
      .stat_timeouts (stat_timeouts)
`endif
   );

   // Core model: done pulses core_lat cycles after the strobe-low cycle.
   always @(negedge clock) begin
      core_done = 1'b0;
      if (reset) begin
         core_cnt = 0;
      end else begin
         if (core_cnt > 0) begin
            core_cnt = core_cnt - 1;
            if (core_cnt == 0) begin
               core_done  = 1'b1;
               core_x_out = core_val;
            end
         end
         if (core_stbi === 1'b0 && core_lat > 0) begin
            core_cnt = core_lat;
            core_val = core_x_in ^ 6'h0E;
         end
      end
   end

   // Response monitor against the scoreboard.
   always @(negedge clock) begin
      if (reset === 1'b0 && rsp_valid !== 4'b0) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got rsp_valid=%b, required no response", rsp_valid);
         end else begin
            mon_e = sb.pop_front();
            if (rsp_valid !== mon_e.vld || rsp_data !== mon_e.data || rsp_err !== mon_e.err) begin
               errors++;
               $display("FAIL rsp_compare: got vld=%b data=%h err=%b, required vld=%b data=%h err=%b",
                        rsp_valid, rsp_data, rsp_err, mon_e.vld, mon_e.data, mon_e.err);
            end
         end
      end
   end

   task automatic do_reset();
      reset    = 1'b1;
      req      = 4'b0;
      core_lat = 0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   // Drives one job for requester idx and queues its expected response.
   // Returns with ok=1 at the negedge where its grant is visible.
   task automatic launch(input int idx, input logic [5:0] d, input int lat,
                         input logic exp_err, output bit ok);
      exp_t e;
      int   i;
      words[idx[1:0]] = d;
      core_lat        = lat;
      e.vld  = 4'b0001 << idx[1:0];
      e.data = exp_err ? 6'h00 : (d ^ 6'h0E);
      e.err  = exp_err;
      sb.push_back(e);
      req[idx[1:0]] = 1'b1;
      i = 0;
      do begin
         @(negedge clock);
         i++;
      end while (gnt[idx[1:0]] !== 1'b1 && i < 200);
      ok = (gnt[idx[1:0]] === 1'b1);
      req[idx[1:0]] = 1'b0;
   endtask

   task automatic drain(input string name);
      int cyc = 0;
      while (sb.size() > 0 && cyc < 500) begin
         @(negedge clock);
         cyc++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req   = 4'b0;
      repeat (3) @(negedge clock);
      checks += 7;
      if (gnt !== 4'b0)       begin errors++; $display("FAIL reset_gnt: got %b, required 0000", gnt); end
      if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0000", rsp_valid); end
      if (rsp_data !== 6'h0)  begin errors++; $display("FAIL reset_rsp_data: got %h, required 00", rsp_data); end
      if (rsp_err !== 1'b0)   begin errors++; $display("FAIL reset_rsp_err: got %b, required 0", rsp_err); end
      if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      if (core_stbi !== 1'b1) begin errors++; $display("FAIL reset_stbi: got %b, required 1", core_stbi); end
      if (core_x_in !== 6'h0) begin errors++; $display("FAIL reset_x_in: got %h, required 00", core_x_in); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      exp_t e;
      int   i = 0;
      do_reset();
      words[0] = 6'h05;
      core_lat = 3;
      e.vld = 4'b0001; e.data = 6'h0B; e.err = 1'b0;
      sb.push_back(e);
      req = 4'b0001;
      do begin @(negedge clock); i++; end while (gnt === 4'b0 && i < 50);
      checks += 4;
      if (gnt !== 4'b0001)    begin errors++; $display("FAIL single_gnt: got %b, required 0001", gnt); end
      if (core_stbi !== 1'b0) begin errors++; $display("FAIL single_stbi_low: got %b, required 0", core_stbi); end
      if (core_x_in !== 6'h05) begin errors++; $display("FAIL single_x_in: got %h, required 05", core_x_in); end
      if (busy !== 1'b1)      begin errors++; $display("FAIL single_busy: got %b, required 1", busy); end
      req = 4'b0;
      @(negedge clock);
      checks += 2;
      if (gnt !== 4'b0)       begin errors++; $display("FAIL single_gnt_pulse: got %b, required 0000", gnt); end
      if (core_stbi !== 1'b1) begin errors++; $display("FAIL single_stbi_pulse: got %b, required 1", core_stbi); end
      drain("single");
   endtask

   task automatic test_round_robin();
      logic [3:0] order [5];
      exp_t e;
      int   k = 0, low = 0, cyc = 0;
      order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      words[0] = 6'h04; words[1] = 6'h13; words[2] = 6'h22; words[3] = 6'h31;
      core_lat = 2;
      for (int j = 0; j < 5; j++) begin
         e.vld  = order[j];
         e.data = (j == 0 || j == 4) ? 6'h0A : (j == 1) ? 6'h1D : (j == 2) ? 6'h2C : 6'h3F;
         e.err  = 1'b0;
         sb.push_back(e);
      end
      req = 4'b1111;
      while (k < 5 && cyc < 300) begin
         @(negedge clock);
         cyc++;
         if (busy === 1'b1 && low > 0) begin
            if (k >= 1) begin
               checks++;
               if (low != 1) begin errors++; $display("FAIL rr_busy_gap: got %0d idle cycles, required 1", low); end
            end
            low = 0;
         end else if (busy !== 1'b1) begin
            low++;
         end
         if (gnt !== 4'b0) begin
            checks++;
            if (gnt !== order[k]) begin
               errors++;
               $display("FAIL rr_grant%0d: got %b, required %b", k, gnt, order[k]);
            end
            k++;
            if (k == 5) req = 4'b0;
         end
      end
      req = 4'b0;
      checks++;
      if (k != 5) begin errors++; $display("FAIL rr_grant_count: got %0d grants, required 5", k); end
      drain("rr");
   endtask

   task automatic test_timeout();
      bit ok;
      int cyc;
      do_reset();
      launch(1, 6'h15, 0, 1'b1, ok);
      cyc = 0;
      do begin @(negedge clock); cyc++; end while (rsp_valid === 4'b0 && cyc < 200);
      checks += 2;
      if (!ok)       begin errors++; $display("FAIL timeout_grant: got no grant, required grant"); end
      if (cyc != 66) begin errors++; $display("FAIL timeout_latency: got %0d cycles, required 66", cyc); end
      drain("timeout");
      launch(1, 6'h2B, 1, 1'b0, ok);
      cyc = 0;
      do begin @(negedge clock); cyc++; end while (rsp_valid === 4'b0 && cyc < 200);
      checks += 2;
      if (!ok)      begin errors++; $display("FAIL after_timeout_grant: got no grant, required grant"); end
      if (cyc != 3) begin errors++; $display("FAIL min_latency: got %0d cycles, required 3", cyc); end
      drain("after_timeout");
   endtask

   task automatic test_done_at_timeout();
      bit ok;
      int cyc = 0;
      do_reset();
      launch(2, 6'h24, 64, 1'b0, ok);
      do begin @(negedge clock); cyc++; end while (rsp_valid === 4'b0 && cyc < 200);
      checks += 2;
      if (!ok)       begin errors++; $display("FAIL edge_grant: got no grant, required grant"); end
      if (cyc != 66) begin errors++; $display("FAIL edge_latency: got %0d cycles, required 66", cyc); end
      drain("edge");
   endtask

   task automatic test_reset_in_wait();
      exp_t e;
      int   i = 0;
      do_reset();
      words[2] = 6'h10;
      core_lat = 0;
      req = 4'b0100;
      do begin @(negedge clock); i++; end while (gnt === 4'b0 && i < 50);
      req = 4'b0;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks += 4;
      if (rsp_valid !== 4'b0) begin errors++; $display("FAIL rstwait_rsp_valid: got %b, required 0000", rsp_valid); end
      if (core_stbi !== 1'b1) begin errors++; $display("FAIL rstwait_stbi: got %b, required 1", core_stbi); end
      if (busy !== 1'b0)      begin errors++; $display("FAIL rstwait_busy: got %b, required 0", busy); end
      if (gnt !== 4'b0)       begin errors++; $display("FAIL rstwait_gnt: got %b, required 0000", gnt); end
      reset = 1'b0;
      words[0] = 6'h07; words[2] = 6'h09;
      core_lat = 2;
      e.vld = 4'b0001; e.data = 6'h09; e.err = 1'b0; sb.push_back(e);
      e.vld = 4'b0100; e.data = 6'h07; e.err = 1'b0; sb.push_back(e);
      req = 4'b0101;
      i = 0;
      do begin @(negedge clock); i++; end while (gnt === 4'b0 && i < 50);
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL rstwait_first: got %b, required 0001", gnt); end
      req = 4'b0100;
      i = 0;
      do begin @(negedge clock); i++; end while (gnt === 4'b0 && i < 50);
      checks++;
      if (gnt !== 4'b0100) begin errors++; $display("FAIL rstwait_second: got %b, required 0100", gnt); end
      req = 4'b0;
      drain("rstwait");
   endtask

`ifdef SCHED_STATS_EN
   task automatic test_stats();
      bit ok;
      int bad = 0;
      do_reset();
      for (int n = 0; n < 3; n++) begin
         launch(1, 6'(n + 1), 2, 1'b0, ok);
         if (!ok) bad++;
      end
      launch(1, 6'h3F, 0, 1'b1, ok);
      if (!ok) bad++;
      drain("stats");
      @(negedge clock);
      checks += 4;
      if (bad != 0) begin errors++; $display("FAIL stats_grants: got %0d missed grants, required 0", bad); end
      if (stat_jobs[15:8] !== 8'd3) begin errors++; $display("FAIL stats_jobs1: got %0d, required 3", stat_jobs[15:8]); end
      if (stat_jobs[7:0] !== 8'd0)  begin errors++; $display("FAIL stats_jobs0: got %0d, required 0", stat_jobs[7:0]); end
      if (stat_timeouts !== 8'd1)   begin errors++; $display("FAIL stats_timeouts: got %0d, required 1", stat_timeouts); end
      bad = 0;
      for (int n = 0; n < 300; n++) begin
         launch(1, 6'(n), 1, 1'b0, ok);
         if (!ok) bad++;
      end
      drain("stats_sat");
      @(negedge clock);
      checks += 3;
      if (bad != 0) begin errors++; $display("FAIL stats_sat_grants: got %0d missed grants, required 0", bad); end
      if (stat_jobs[15:8] !== 8'd255) begin errors++; $display("FAIL stats_sat: got %0d, required 255", stat_jobs[15:8]); end
      if (stat_timeouts !== 8'd1)     begin errors++; $display("FAIL stats_sat_timeouts: got %0d, required 1", stat_timeouts); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 4; i++) words[i] = 6'h0;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_done_at_timeout();
      test_reset_in_wait();
`ifdef SCHED_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
